fetch_unit: RTL

Instruction fetch stage of the SWT16 core: the producer side of the decoder's `in_instr`/`in_pc`/`in_flush` interface. It owns the fetch PC and drives the program-memory address, a synchronous-read memory with 1-cycle latency. It delivers one instruction word per cycle with its PC, and redirects to a jump target supplied by the execute stage. Flush is raised for every wrong-path word so the decoder discards it.

---
 rtl/swt16_pkg.sv | 18 +
 rtl/fetch_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/swt16_pkg.sv
// SWT16 shared definitions.
// Widths, NOP encoding and fetch-stage state type.
package swt16_pkg;

  localparam int PMEM_ADDR_WIDTH = 12;
  localparam int PMEM_WORD_WIDTH = 16;
  localparam int PC_WIDTH        = PMEM_ADDR_WIDTH;
  localparam int IALU_WORD_WIDTH = 16;

  localparam logic [PMEM_WORD_WIDTH-1:0] NOP = 16'h0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// SWT16 instruction fetch stage.
// Drives 1-cycle sync program memory, stalls, redirects.
module fetch_unit
  import swt16_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
  input  logic [PMEM_WORD_WIDTH-1:0] in_pmem_rdata,
  input  logic                       in_stall,
  input  logic                       in_jump_valid,
  input  logic [IALU_WORD_WIDTH-1:0] in_jump_target,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_instr_valid,
  output logic                       out_flush
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_fetch_q, pc_fetch_d;
  logic [PC_WIDTH-1:0] pc_inflight_q, pc_inflight_d;
  logic                inflight_valid_q, inflight_valid_d;

  logic [PC_WIDTH-1:0] jt;
  logic                unused_jt;

  assign jt        = in_jump_target[PC_WIDTH-1:0];
  assign unused_jt = ^in_jump_target[IALU_WORD_WIDTH-1:PC_WIDTH];

  // State and PC registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= BOOT;
      pc_fetch_q       <= '0;
      pc_inflight_q    <= '0;
      inflight_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_fetch_q       <= pc_fetch_d;
      pc_inflight_q    <= pc_inflight_d;
      inflight_valid_q <= inflight_valid_d;
    end
  end

  // Next-state, address mux and decoder-facing outputs.
  always_comb begin
    state_d          = state_q;
    pc_fetch_d       = pc_fetch_q;
    pc_inflight_d    = pc_inflight_q;
    inflight_valid_d = inflight_valid_q;
    out_pmem_addr    = pc_fetch_q;
    out_instr        = NOP;
    out_pc           = '0;
    out_instr_valid  = 1'b0;
    out_flush        = 1'b0;

    if (in_jump_valid) begin
      out_flush        = 1'b1;
      out_pmem_addr    = jt;
      pc_inflight_d    = jt;
      pc_fetch_d       = jt + PC_WIDTH'(1);
      inflight_valid_d = 1'b0;
      state_d          = FLUSH;
    end else begin
      unique case (state_q)
        BOOT: begin
          out_pmem_addr    = pc_fetch_q;
          pc_inflight_d    = pc_fetch_q;
          pc_fetch_d       = pc_fetch_q + PC_WIDTH'(1);
          inflight_valid_d = 1'b1;
          state_d          = RUN;
        end
        RUN: begin
          if (inflight_valid_q) begin
            out_instr = in_pmem_rdata;
            out_pc    = pc_inflight_q;
          end
          out_instr_valid = inflight_valid_q;
          if (in_stall) begin
            out_pmem_addr = pc_inflight_q;
          end else begin
            out_pmem_addr = pc_fetch_q;
            pc_inflight_d = pc_fetch_q;
            pc_fetch_d    = pc_fetch_q + PC_WIDTH'(1);
          end
        end
        FLUSH: begin
          out_flush        = 1'b1;
          out_pmem_addr    = pc_inflight_q;
          inflight_valid_d = 1'b1;
          state_d          = RUN;
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end

    if (!reset) begin
      out_pmem_addr   = '0;
      out_instr       = NOP;
      out_pc          = '0;
      out_instr_valid = 1'b0;
      out_flush       = 1'b0;
    end
  end

endmodule
